// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared state encoding and default timing for the pedestrian signal stage
package ped_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WALK,
    FLASH,
    CLEAR,
    FAULT
  } ped_state_e;

  localparam int WALK_CYCLES_DEF  = 4;
  localparam int FLASH_CYCLES_DEF = 4;
  localparam int CNT_W_DEF        = 4;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer with rising-edge detect for an async input
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= async_i;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign rise_o = r_sync2 & ~r_sync_d;

endmodule

// File: rtl/ped_signal_ctrl.sv
// rtl/ped_signal_ctrl.sv - pedestrian WALK/DON'T-WALK controller slaved to the vehicle lamps
module ped_signal_ctrl
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = WALK_CYCLES_DEF,
  parameter int FLASH_CYCLES = FLASH_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             red_i,
  input  logic             yellow_i,
  input  logic             green_i,
  input  logic             btn_i,
  output logic             walk_o,
  output logic             dont_walk_o,
  output logic             req_pending_o,
  output logic [CNT_W-1:0] countdown_o,
  output logic             fault_o
);

  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);

  ped_state_e       r_state;
  ped_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_red_only_q;
  logic             r_req;
  logic             r_blink;
  logic             w_red_only;
  logic             w_illegal;
  logic             w_start;
  logic             w_btn_rise;
  logic             w_walk_entry;

  btn_sync_edge u_btn_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (btn_i),
    .rise_o  (w_btn_rise)
  );

  assign w_red_only   = red_i & ~yellow_i & ~green_i;
  assign w_illegal    = green_i & (red_i | yellow_i);
  // Only the first red-only cycle may launch a crossing; late requests wait a full phase.
  assign w_start      = w_red_only & ~r_red_only_q & r_req;
  assign w_walk_entry = (w_state_next == WALK) & (r_state != WALK);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_illegal) begin
      w_state_next = FAULT;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            w_state_next = WALK;
            w_cnt_next   = C_WALK_LOAD;
          end
        end
        WALK: begin
          if (!w_red_only) begin
            w_state_next = IDLE;
          end else if (r_cnt == '0) begin
            w_state_next = FLASH;
            w_cnt_next   = C_FLASH_LOAD;
          end else begin
            w_cnt_next = r_cnt - C_ONE;
          end
        end
        FLASH: begin
          if (!w_red_only) begin
            w_state_next = IDLE;
          end else if (r_cnt == '0) begin
            w_state_next = CLEAR;
          end else begin
            w_cnt_next = r_cnt - C_ONE;
          end
        end
        CLEAR: begin
          if (!w_red_only) begin
            w_state_next = IDLE;
          end
        end
        FAULT:   w_state_next = FAULT;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_red_only_q <= 1'b0;
      r_req        <= 1'b0;
      r_blink      <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_red_only_q <= w_red_only;
      // Blink phase restarts lit on every state change so FLASH and FAULT open with DON'T-WALK on.
      r_blink      <= (w_state_next != r_state) ? 1'b1 : ~r_blink;
      if (w_illegal || (r_state == FAULT)) begin
        r_req <= 1'b0;
      end else if (w_btn_rise) begin
        r_req <= 1'b1;
      end else if (w_walk_entry) begin
        r_req <= 1'b0;
      end
    end
  end

  always_comb begin
    dont_walk_o = 1'b1;
    countdown_o = '0;
    case (r_state)
      WALK: begin
        dont_walk_o = ~w_red_only;
        countdown_o = r_cnt + C_ONE;
      end
      FLASH: begin
        dont_walk_o = r_blink;
        countdown_o = r_cnt + C_ONE;
      end
      FAULT:   dont_walk_o = r_blink;
      default: dont_walk_o = 1'b1;
    endcase
  end

  // Gated by the live lamp so WALK goes dark the moment vehicle red drops.
  assign walk_o        = (r_state == WALK) & w_red_only;
  assign fault_o       = (r_state == FAULT);
  assign req_pending_o = r_req;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// tb/tb_ped_signal_ctrl.sv - scoreboard bench for ped_signal_ctrl
module tb_ped_signal_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       red, yellow, green, btn;
  logic       walk, dw, req, fault;
  logic [3:0] cd;

  typedef struct {
    string      tag;
    logic [4:0] care;
    logic       w;
    logic       dw;
    logic       req;
    logic [3:0] cd;
    logic       f;
  } exp_t;

  localparam logic [4:0] ALL = 5'b11111;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ped_signal_ctrl #(
    .WALK_CYCLES  (4),
    .FLASH_CYCLES (4),
    .CNT_W        (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .red_i         (red),
    .yellow_i      (yellow),
    .green_i       (green),
    .btn_i         (btn),
    .walk_o        (walk),
    .dont_walk_o   (dw),
    .req_pending_o (req),
    .countdown_o   (cd),
    .fault_o       (fault)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic y, input logic g, input logic b,
                     input logic [4:0] care, input logic ew, input logic edw, input logic ereq,
                     input logic [3:0] ecd, input logic ef);
    exp_t e;
    e.tag = tag; e.care = care; e.w = ew; e.dw = edw; e.req = ereq; e.cd = ecd; e.f = ef;
    sb.push_back(e);
    red = r; yellow = y; green = g; btn = b;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.care[4]) chk_eq($sformatf("%s:walk", e.tag), {31'd0, walk}, {31'd0, e.w});
    if (e.care[3]) chk_eq($sformatf("%s:dont_walk", e.tag), {31'd0, dw}, {31'd0, e.dw});
    if (e.care[2]) chk_eq($sformatf("%s:req", e.tag), {31'd0, req}, {31'd0, e.req});
    if (e.care[1]) chk_eq($sformatf("%s:countdown", e.tag), {28'd0, cd}, {28'd0, e.cd});
    if (e.care[0]) chk_eq($sformatf("%s:fault", e.tag), {31'd0, fault}, {31'd0, e.f});
  endtask

  // Twelve red-only cycles: 4 WALK, 4 FLASH, then CLEAR.
  task automatic crossing(input string tag, input logic b, input logic ereq);
    for (int i = 0; i < 12; i++) begin
      if (i < 4)      cyc(tag, 1, 0, 0, b, ALL, 1, 0, ereq, 4'(4 - i), 0);
      else if (i < 8) cyc(tag, 1, 0, 0, b, ALL, 0, (i % 2 == 0), ereq, 4'(8 - i), 0);
      else            cyc(tag, 1, 0, 0, b, ALL, 0, 1, ereq, 4'd0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; red = 1'b0; yellow = 1'b0; green = 1'b1; btn = 1'b0;
    cyc("rst0", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);
    cyc("rst1", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);
    rst = 1'b0;

    cyc("btn_lat0", 0, 0, 1, 1, ALL, 0, 1, 0, 0, 0);
    cyc("btn_lat1", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);
    cyc("btn_lat2", 0, 0, 1, 0, ALL, 0, 1, 1, 0, 0);
    cyc("yellow1",  0, 1, 0, 0, ALL, 0, 1, 1, 0, 0);
    crossing("cross1", 0, 0);
    cyc("green1",   0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);

    for (int i = 0; i < 10; i++)
      cyc("late", 1, 0, 0, (i == 2), ALL, 0, 1, (i >= 4), 0, 0);
    cyc("late_green0", 0, 0, 1, 0, ALL, 0, 1, 1, 0, 0);
    cyc("late_green1", 0, 0, 1, 0, ALL, 0, 1, 1, 0, 0);
    crossing("cross2", 0, 0);
    cyc("green2", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);

    cyc("tr_btn0", 0, 0, 1, 1, ALL, 0, 1, 0, 0, 0);
    cyc("tr_btn1", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);
    cyc("tr_btn2", 0, 0, 1, 0, ALL, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("trunc", 1, 0, 0, 0, ALL, 1, 0, 0, 4'(4 - i), 0);
    red = 1'b0; green = 1'b1;
    #1;
    chk_eq("trunc_walk_comb", {31'd0, walk}, 32'd0);
    cyc("trunc_idle0", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);
    cyc("trunc_idle1", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);

    cyc("hold_pre0", 0, 0, 1, 1, ALL, 0, 1, 0, 0, 0);
    cyc("hold_pre1", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);
    cyc("hold_pre2", 0, 0, 1, 0, ALL, 0, 1, 1, 0, 0);
    cyc("hold_g0",   0, 0, 1, 1, ALL, 0, 1, 1, 0, 0);
    cyc("hold_g1",   0, 0, 1, 1, ALL, 0, 1, 1, 0, 0);
    crossing("cross3", 1, 1);
    for (int i = 0; i < 6; i++)
      cyc("hold_tail", 0, 0, 1, 1, ALL, 0, 1, 1, 0, 0);
    cyc("hold_rel", 0, 0, 1, 0, ALL, 0, 1, 1, 0, 0);
    crossing("cross4", 0, 0);
    cyc("green4", 0, 0, 1, 0, ALL, 0, 1, 0, 0, 0);

    cyc("illegal", 1, 0, 1, 0, ALL, 0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i < 3) cyc("fault_g", 0, 0, 1, (i == 1), ALL, 0, (i % 2 == 1), 0, 0, 1);
      else       cyc("fault_r", 1, 0, 0, 0,        ALL, 0, (i % 2 == 1), 0, 0, 1);
    end

    rst = 1'b1;
    cyc("rst_exit", 1, 0, 0, 0, ALL, 0, 1, 0, 0, 0);
    rst = 1'b0;
    cyc("post_rst", 1, 0, 0, 0, ALL, 0, 1, 0, 0, 0);

    chk_eq("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
